// File: rtl/fifo_rd_stream.sv
// Read side of a FIFO turned into a valid/ready stream through a 2-entry skid buffer.
// Optional burst framing (m_last) is compiled in when FIFO_RD_STREAM_LAST_EN is defined.
module fifo_rd_stream #(
  parameter int DATA_WIDTH = 8,
  parameter int BURST_LEN  = 4
) (
  input  logic                  rd_clk,
  input  logic                  rd_rst,
  input  logic                  FIFO_empty,
  input  logic [DATA_WIDTH-1:0] data_out,
  output logic                  rd_en,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [1:0]            level,
  output logic                  m_last
);

  if (BURST_LEN < 1 || BURST_LEN > 255) begin : g_bad_burst_len
    $error("fifo_rd_stream: BURST_LEN must be within 1..255");
  end

  // Handshake: a word moves downstream on every rising edge where m_valid && m_ready;
  // m_valid depends only on registered state, never on m_ready.
  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} lvl_e;

  lvl_e                  state_q, state_d;
  logic                  pend_q;
  logic                  pop;
  logic                  hd_q;
  logic                  wr_idx;
  logic [2:0]            occ;
  logic [DATA_WIDTH-1:0] mem_q [2];

  assign pop    = (state_q != EMPTY) && m_ready;
  assign wr_idx = hd_q ^ state_q[0];
  assign m_data = mem_q[hd_q];

  always_ff @(posedge rd_clk or posedge rd_rst) begin
    if (rd_rst) state_q <= EMPTY;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case ({pend_q, pop})
      2'b10:   state_d = (state_q == EMPTY) ? ONE : FULL;
      2'b01:   state_d = (state_q == FULL) ? ONE : EMPTY;
      default: state_d = state_q;
    endcase
  end

  // Reads are issued only when the returning word is guaranteed a free slot.
  always_comb begin
    m_valid = (state_q != EMPTY);
    level   = state_q;
    occ     = {1'b0, state_q} + {2'b00, pend_q} - {2'b00, pop};
    rd_en   = !rd_rst && !FIFO_empty && (occ < 3'd2);
  end

  always_ff @(posedge rd_clk or posedge rd_rst) begin
    if (rd_rst) begin
      pend_q   <= 1'b0;
      hd_q     <= 1'b0;
      mem_q[0] <= '0;
      mem_q[1] <= '0;
    end else begin
      pend_q <= rd_en;
      if (pend_q) mem_q[wr_idx] <= data_out;
      if (pop)    hd_q <= ~hd_q;
    end
  end

`ifdef FIFO_RD_STREAM_LAST_EN
  localparam logic [7:0] LAST_IDX = 8'(BURST_LEN - 1);
  logic [7:0] burst_cnt_q;

  always_ff @(posedge rd_clk or posedge rd_rst) begin
    if (rd_rst)   burst_cnt_q <= 8'd0;
    else if (pop) burst_cnt_q <= (burst_cnt_q == LAST_IDX) ? 8'd0 : burst_cnt_q + 8'd1;
  end

  assign m_last = m_valid && (burst_cnt_q == LAST_IDX);
`else
  assign m_last = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Bench for fifo_rd_stream: queue-based reference model checked every cycle plus directed scenarios.
// Compile with or without FIFO_RD_STREAM_LAST_EN; m_last expectations follow the macro.
module tb_fifo_rd_stream;
  localparam int W  = 8;
  localparam int BL = 4;

  logic         rd_clk = 1'b0;
  logic         rd_rst;
  logic         FIFO_empty;
  logic [W-1:0] data_out;
  logic         rd_en;
  logic [W-1:0] m_data;
  logic         m_valid;
  logic         m_ready;
  logic [1:0]   level;
  logic         m_last;

  always #5 rd_clk = ~rd_clk;

  fifo_rd_stream #(.DATA_WIDTH(W), .BURST_LEN(BL)) dut (
    .rd_clk     (rd_clk),
    .rd_rst     (rd_rst),
    .FIFO_empty (FIFO_empty),
    .data_out   (data_out),
    .rd_en      (rd_en),
    .m_data     (m_data),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .level      (level),
    .m_last     (m_last)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [W-1:0] src_q[$];
  logic [W-1:0] exp_q[$];
  logic [W-1:0] mbuf[$];
  logic [W-1:0] got_q[$];
  logic         last_q[$];
  int           pop_cyc_q[$];

  bit rd_seen   = 1'b0;
  int rd_cnt    = 0;
  int valid_cnt = 0;
  int max_level = 0;
  int cyc       = 0;

  bit           m_inflight = 1'b0;
  bit           pre_pop    = 1'b0;
  bit           pre_rd     = 1'b0;
  bit           prev_rst   = 1'b1;
  bit           exp_valid, exp_pop, exp_rd, exp_last;
  logic [W-1:0] cap_val    = '0;
  logic [W-1:0] want;
  int           popcnt     = 0;
  int           lost;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: the buffer is a queue of words, a read returns one cycle later.
  initial begin : compare
    forever begin
      @(negedge rd_clk);
      #2;
      cyc++;
      if (!prev_rst) begin
        if (pre_pop) begin
          void'(mbuf.pop_front());
          popcnt = (popcnt + 1) % BL;
        end
        if (m_inflight) mbuf.push_back(cap_val);
        m_inflight = pre_rd;
      end
      if (rd_rst) begin
        if (!prev_rst) begin
          lost = mbuf.size() + int'(m_inflight);
          repeat (lost) if (exp_q.size() > 0) void'(exp_q.pop_front());
        end
        mbuf.delete();
        m_inflight = 1'b0;
        popcnt     = 0;
      end
      exp_valid = (mbuf.size() != 0);
      exp_pop   = exp_valid && m_ready;
      exp_rd    = !rd_rst && !FIFO_empty &&
                  (mbuf.size() + int'(m_inflight) - int'(exp_pop) < 2);
`ifdef FIFO_RD_STREAM_LAST_EN
      exp_last  = exp_valid && (popcnt == BL - 1);
`else
      exp_last  = 1'b0;
`endif
      check("rd_en", 32'(rd_en), 32'(exp_rd));
      check("m_valid", 32'(m_valid), 32'(exp_valid));
      check("level", 32'(level), 32'(mbuf.size()));
      check("m_last", 32'(m_last), 32'(exp_last));
      if (exp_valid) check("m_data", 32'(m_data), 32'(mbuf[0]));
      if (exp_pop) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL order: got %0h expected no word at %0t", m_data, $time);
        end else begin
          want = exp_q.pop_front();
          check("order", 32'(m_data), 32'(want));
        end
        got_q.push_back(m_data);
        last_q.push_back(m_last);
        pop_cyc_q.push_back(cyc);
      end
      if (rd_en) rd_cnt++;
      if (m_valid) valid_cnt++;
      if (int'(level) > max_level) max_level = int'(level);
      pre_pop  = exp_pop;
      pre_rd   = exp_rd;
      cap_val  = data_out;
      prev_rst = rd_rst;
      rd_seen  = rd_en;
    end
  end

  task automatic push_word(input logic [W-1:0] w);
    src_q.push_back(w);
    exp_q.push_back(w);
  endtask

  // One cycle: the FIFO answers the read sampled at the last edge, then new inputs apply.
  task automatic tick(input logic rdy, input logic rst);
    @(negedge rd_clk);
    if (rd_seen && src_q.size() > 0) data_out = src_q.pop_front();
    rd_rst     = rst;
    m_ready    = rdy;
    FIFO_empty = (src_q.size() == 0);
  endtask

  task automatic clear_stats();
    rd_cnt    = 0;
    valid_cnt = 0;
    max_level = 0;
    got_q.delete();
    last_q.delete();
    pop_cyc_q.delete();
  endtask

  logic [15:0] pat;
  logic [W-1:0] words5 [5];
  bit exp_l;

  initial begin : driver
    rd_rst     = 1'b1;
    m_ready    = 1'b0;
    FIFO_empty = 1'b1;
    data_out   = '0;

    // Reset with a non-empty FIFO, then stream three words.
    push_word(8'h11);
    push_word(8'h22);
    push_word(8'h33);
    tick(1'b0, 1'b1);
    tick(1'b0, 1'b1);
    #3;
    check("rst_rd_en", 32'(rd_en), 32'd0);
    check("rst_m_valid", 32'(m_valid), 32'd0);
    check("rst_level", 32'(level), 32'd0);
    check("rst_m_data", 32'(m_data), 32'd0);
    clear_stats();
    tick(1'b1, 1'b0);
    #3;
    check("release_rd_en", 32'(rd_en), 32'd1);
    repeat (6) tick(1'b1, 1'b0);
    #3;
    check("stream_rd_cnt", 32'(rd_cnt), 32'd3);
    check("stream_max_level", 32'(max_level), 32'd1);
    check("stream_count", 32'(got_q.size()), 32'd3);
    if (got_q.size() == 3) begin
      check("stream_w0", 32'(got_q[0]), 32'h11);
      check("stream_w1", 32'(got_q[1]), 32'h22);
      check("stream_w2", 32'(got_q[2]), 32'h33);
      check("stream_back_to_back", 32'(pop_cyc_q[2] - pop_cyc_q[0]), 32'd2);
    end

    // Backpressure: five words, downstream stalled.
    words5[0] = 8'hA1; words5[1] = 8'hA2; words5[2] = 8'hA3;
    words5[3] = 8'hA4; words5[4] = 8'hA5;
    for (int i = 0; i < 5; i++) push_word(words5[i]);
    clear_stats();
    repeat (6) tick(1'b0, 1'b0);
    #3;
    check("bp_rd_cnt", 32'(rd_cnt), 32'd2);
    check("bp_level", 32'(level), 32'd2);
    check("bp_m_valid", 32'(m_valid), 32'd1);
    check("bp_m_data", 32'(m_data), 32'hA1);
    repeat (8) tick(1'b1, 1'b0);
    #3;
    check("bp_count", 32'(got_q.size()), 32'd5);
    for (int i = 0; i < 5; i++)
      if (i < got_q.size()) check("bp_word", 32'(got_q[i]), 32'(words5[i]));
    check("bp_level_end", 32'(level), 32'd0);

    // Empty FIFO with ready high, then a single word arrives.
    clear_stats();
    repeat (5) tick(1'b1, 1'b0);
    #3;
    check("empty_rd_cnt", 32'(rd_cnt), 32'd0);
    check("empty_valid_cnt", 32'(valid_cnt), 32'd0);
    push_word(8'h2A);
    tick(1'b1, 1'b0);
    #3;
    check("single_rd_en", 32'(rd_en), 32'd1);
    check("single_valid_c0", 32'(m_valid), 32'd0);
    tick(1'b1, 1'b0);
    #3;
    check("single_valid_c1", 32'(m_valid), 32'd0);
    tick(1'b1, 1'b0);
    #3;
    check("single_valid_c2", 32'(m_valid), 32'd1);
    check("single_data", 32'(m_data), 32'h2A);
    repeat (2) tick(1'b1, 1'b0);

    // Reset while a read is in flight: that word is lost.
    clear_stats();
    push_word(8'h55);
    tick(1'b1, 1'b0);
    #3;
    check("mid_rd_en", 32'(rd_en), 32'd1);
    tick(1'b1, 1'b1);
    #3;
    check("mid_rst_rd_en", 32'(rd_en), 32'd0);
    check("mid_rst_level", 32'(level), 32'd0);
    tick(1'b1, 1'b1);
    tick(1'b1, 1'b0);
    clear_stats();
    repeat (4) tick(1'b1, 1'b0);
    #3;
    check("mid_valid_cnt", 32'(valid_cnt), 32'd0);
    check("mid_level", 32'(level), 32'd0);
    check("mid_delivered", 32'(got_q.size()), 32'd0);

    // Irregular ready pattern exercises simultaneous capture and pop.
    clear_stats();
    for (int i = 0; i < 6; i++) push_word(8'(8'h60 + i));
    pat = 16'b1010_0110_0011_1001;
    for (int i = 0; i < 16; i++) tick(pat[i], 1'b0);
    repeat (6) tick(1'b1, 1'b0);
    #3;
    check("mix_count", 32'(got_q.size()), 32'd6);
    for (int i = 0; i < 6; i++)
      if (i < got_q.size()) check("mix_word", 32'(got_q[i]), 32'(8'h60 + i));

    // Burst framing over nine words after a clean reset.
    tick(1'b1, 1'b1);
    tick(1'b1, 1'b0);
    clear_stats();
    for (int i = 0; i < 9; i++) push_word(8'(8'h80 + i));
    repeat (14) tick(1'b1, 1'b0);
    #3;
    check("burst_count", 32'(got_q.size()), 32'd9);
    for (int i = 0; i < 9; i++) begin
`ifdef FIFO_RD_STREAM_LAST_EN
      exp_l = (i == 3) || (i == 7);
`else
      exp_l = 1'b0;
`endif
      if (i < last_q.size()) check("burst_last", 32'(last_q[i]), 32'(exp_l));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
